imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 161 ++++++++++++++++
 tb/tb_imem_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte loader for a 16x8 instruction memory
//
// Purpose: receives a frame {HEADER, N, N data bytes, XOR checksum} from a
// byte producer, writes the data bytes into a 16-entry instruction memory
// and holds the CPU in reset until a frame has been fully verified.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   start        begin a load session (honoured in IDLE, DONE, ERR only)
//   in_valid     producer has a byte on in_data
//   in_data      frame byte
//   in_ready     loader accepts a byte this cycle
//   rd_sel       CPU read address
//   instruction  combinational read data, mem[rd_sel]
//   cpu_hold     high while the CPU must be held in reset
//   done         last session loaded and checksum-verified
//   error        last session aborted
//   err_code     00 none, 01 bad header, 10 bad length, 11 checksum mismatch
//   count        data bytes written in the current/last session, 0..16
module imem_loader #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic [3:0] rd_sel,
  output logic [7:0] instruction,
  output logic       cpu_hold,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [4:0] count
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  state_t           state_q, state_d;
  logic [15:0][7:0] mem_q, mem_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [4:0]       len_q, len_d;
  logic [7:0]       acc_q, acc_d;
  logic [1:0]       code_q, code_d;
  logic             accept;

  // Only the four frame-receiving states take bytes, so a start pulse in
  // IDLE/DONE/ERR can never collide with an accepted byte.
  assign in_ready    = (state_q == HDR) || (state_q == LEN) ||
                       (state_q == DATA) || (state_q == CSUM);
  assign accept      = in_valid && in_ready;

  assign instruction = mem_q[rd_sel];
  assign done        = (state_q == DONE);
  assign error       = (state_q == ERR);
  assign cpu_hold    = (state_q != DONE);
  assign err_code    = code_q;
  assign count       = cnt_q;

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    acc_d   = acc_q;
    code_d  = code_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = HDR;
          mem_d   = '0;
          cnt_d   = 5'd0;
          len_d   = 5'd0;
          acc_d   = 8'h00;
          code_d  = 2'b00;
        end
      end

      HDR: begin
        if (accept) begin
          if (in_data == HEADER) begin
            state_d = LEN;
          end else begin
            state_d = ERR;
            code_d  = 2'b01;
          end
        end
      end

      LEN: begin
        if (accept) begin
          if ((in_data != 8'd0) && (in_data <= 8'd16)) begin
            len_d   = in_data[4:0];
            state_d = DATA;
          end else begin
            state_d = ERR;
            code_d  = 2'b10;
          end
        end
      end

      DATA: begin
        // cnt_q < len_q <= 16 here, so the low four bits index the memory
        // and the increment can never pass len_q.
        if (accept) begin
          mem_d[cnt_q[3:0]] = in_data;
          acc_d             = acc_q ^ in_data;
          cnt_d             = cnt_q + 5'd1;
          if ((cnt_q + 5'd1) == len_q) begin
            state_d = CSUM;
          end
        end
      end

      CSUM: begin
        if (accept) begin
          if (in_data == acc_q) begin
            state_d = DONE;
          end else begin
            state_d = ERR;
            code_d  = 2'b11;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mem_q   <= '0;
      cnt_q   <= 5'd0;
      len_q   <= 5'd0;
      acc_q   <= 8'h00;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      code_q  <= code_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] rd_sel;
  logic [7:0] instruction;
  logic       cpu_hold;
  logic       done;
  logic       error;
  logic [1:0] err_code;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;

  imem_loader #(.HEADER(8'hA5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .rd_sel      (rd_sel),
    .instruction (instruction),
    .cpu_hold    (cpu_hold),
    .done        (done),
    .error       (error),
    .err_code    (err_code),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0][7:0] b;
    logic [4:0]       nbytes;
    logic             gaps;
    logic             exp_done;
    logic             exp_err;
    logic [1:0]       exp_code;
    logic [4:0]       exp_count;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic gap);
    if (gap) begin
      int idle;
      logic [4:0] cnt_before;
      idle = $urandom_range(0, 3);
      cnt_before = count;
      repeat (idle) @(posedge clk);
      #1;
      chk("gap_count", count, cnt_before);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    chk("in_ready_frame", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_mem_zero(input string name);
    for (int i = 0; i < 16; i++) begin
      rd_sel = i[3:0];
      #1;
      chk(name, instruction, 0);
    end
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    rd_sel   = 4'd0;

    vecs[0] = '0;
    vecs[0].b[0] = 8'hA5; vecs[0].b[1] = 8'h03; vecs[0].b[2] = 8'h11;
    vecs[0].b[3] = 8'h22; vecs[0].b[4] = 8'h33; vecs[0].b[5] = 8'h00;
    vecs[0].nbytes = 5'd6; vecs[0].exp_done = 1'b1; vecs[0].exp_count = 5'd3;

    vecs[1] = '0;
    vecs[1].b[0] = 8'h5A;
    vecs[1].nbytes = 5'd1; vecs[1].exp_err = 1'b1; vecs[1].exp_code = 2'b01;

    vecs[2] = '0;
    vecs[2].b[0] = 8'hA5; vecs[2].b[1] = 8'h11;
    vecs[2].nbytes = 5'd2; vecs[2].exp_err = 1'b1; vecs[2].exp_code = 2'b10;

    vecs[3] = '0;
    vecs[3].b[0] = 8'hA5; vecs[3].b[1] = 8'h00;
    vecs[3].nbytes = 5'd2; vecs[3].exp_err = 1'b1; vecs[3].exp_code = 2'b10;

    vecs[4] = '0;
    vecs[4].b[0] = 8'hA5; vecs[4].b[1] = 8'h02; vecs[4].b[2] = 8'h0F;
    vecs[4].b[3] = 8'hF0; vecs[4].b[4] = 8'h00;
    vecs[4].nbytes = 5'd5; vecs[4].exp_err = 1'b1; vecs[4].exp_code = 2'b11;
    vecs[4].exp_count = 5'd2;

    vecs[5] = '0;
    vecs[5].b[0] = 8'hA5; vecs[5].b[1] = 8'h01; vecs[5].b[2] = 8'h07;
    vecs[5].b[3] = 8'h07;
    vecs[5].nbytes = 5'd4; vecs[5].exp_done = 1'b1; vecs[5].exp_count = 5'd1;

    vecs[6] = '0;
    vecs[6].b[0] = 8'hA5; vecs[6].b[1] = 8'h10;
    for (int i = 0; i < 16; i++) vecs[6].b[2+i] = 8'(i + 1);
    vecs[6].b[18] = 8'h10;
    vecs[6].nbytes = 5'd19; vecs[6].gaps = 1'b1; vecs[6].exp_done = 1'b1;
    vecs[6].exp_count = 5'd16;

    // reset state, asserted and after release
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_count", count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    chk("release_no_start", in_ready, 0);
    chk("release_cpu_hold", cpu_hold, 1);
    in_valid = 1'b0;
    check_mem_zero("release_mem");

    for (int v = 0; v < 7; v++) begin
      do_start();
      chk("start_count", count, 0);
      chk("start_done", done, 0);
      chk("start_error", error, 0);
      chk("start_code", err_code, 0);
      chk("start_hold", cpu_hold, 1);
      for (int k = 0; k < int'(vecs[v].nbytes); k++)
        send_byte(vecs[v].b[k], vecs[v].gaps);
      chk("vec_done", done, vecs[v].exp_done);
      chk("vec_error", error, vecs[v].exp_err);
      chk("vec_code", err_code, vecs[v].exp_code);
      chk("vec_count", count, vecs[v].exp_count);
      chk("vec_hold", cpu_hold, !vecs[v].exp_done);
      chk("vec_in_ready", in_ready, 0);
      for (int i = 0; i < 16; i++) begin
        rd_sel = i[3:0];
        #1;
        chk("vec_mem", instruction,
            (i < int'(vecs[v].exp_count)) ? int'(vecs[v].b[2+i]) : 0);
      end
    end

    // DONE: bytes offered are ignored, memory frozen
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("done_frozen_count", count, 16);
    rd_sel = 4'd0;
    #1;
    chk("done_frozen_mem0", instruction, 8'h01);
    rd_sel = 4'd15;
    #1;
    chk("done_frozen_mem15", instruction, 8'h10);

    // start and a byte on the same edge in DONE: start wins
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    chk("start_vs_byte_ready", in_ready, 0);
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    chk("start_vs_byte_hdr", in_ready, 1);
    chk("start_vs_byte_error", error, 0);
    check_mem_zero("start_vs_byte_mem");

    // start ignored mid-frame: A5,02,05,<start>,06,03 still completes
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h05, 1'b0);
    do_start();
    chk("midstart_count", count, 1);
    send_byte(8'h06, 1'b0);
    send_byte(8'h03, 1'b0);
    chk("midstart_done", done, 1);
    chk("midstart_count2", count, 2);

    // reset mid-frame after two data bytes
    do_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    chk("pre_rst_count", count, 2);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_hold", cpu_hold, 1);
    chk("midrst_done", done, 0);
    chk("midrst_error", error, 0);
    chk("midrst_code", err_code, 0);
    chk("midrst_count", count, 0);
    check_mem_zero("midrst_mem");
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h03;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("postrst_idle", in_ready, 0);
    chk("postrst_count", count, 0);
    check_mem_zero("postrst_mem");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
